ahbslv_mem: RTL and testbench

AHB responder with an internal word-organised SRAM. It is the slave-side counterpart of the `ahbif` master inside `dma`, and serves as the frame-buffer target for the rotate engine's read and write bursts. It decodes single, INCR and INCR4/8/16 transfers of byte, halfword and word size, with a programmable number of wait states. It returns a two-cycle ERROR response for illegal accesses.

---
 rtl/ahbslv_mem.sv | 151 +++++++++++++++
 tb/tb_ahbslv_mem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbslv_mem.sv
// rtl/ahbslv_mem.sv - AHB responder with word-organised SRAM, programmable wait states and ERROR response
`timescale 1ns/1ps
module ahbslv_mem #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        I_AHBS_HCLK,
    input  logic        I_AHBS_RESET,
    input  logic        I_AHBS_HSEL,
    input  logic [31:0] I_AHBS_HADDR,
    input  logic [1:0]  I_AHBS_HTRANS,
    input  logic        I_AHBS_HWRITE,
    input  logic [2:0]  I_AHBS_HSIZE,
    input  logic [2:0]  I_AHBS_HBURST,
    input  logic [31:0] I_AHBS_HWDATA,
    input  logic        I_AHBS_HREADY,
    output logic        O_AHBS_HREADYOUT,
    output logic [1:0]  O_AHBS_HRESP,
    output logic [31:0] O_AHBS_HRDATA
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;
    localparam int         DEPTH  = 1 << AW;
    localparam logic [1:0] WS     = 2'(WAIT_STATES);

    logic [31:0]   mem [DEPTH];
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          valid;
    logic [AW-1:0] cap_idx;
    logic          cap_write;
    logic [1:0]    cap_size;
    logic [1:0]    cap_lane;
    logic [1:0]    wait_cnt;
    logic [31:0]   rdata;

    logic          ready_out;
    logic          capture;
    logic          in_range;
    logic          aligned;
    logic          cap_legal;
    logic [AW-1:0] haddr_idx;
    logic [3:0]    cap_be;
    logic          commit;
    logic          fwd;
    logic [31:0]   old_word;
    logic [31:0]   bus_word;
    logic [31:0]   wr_word;
    logic          unused_ok;

    assign unused_ok = ^{I_AHBS_HBURST, I_AHBS_HTRANS[0]};

    // Only IDLE, DATA and ERR2 present HREADYOUT high, so only they can take an address phase.
    assign ready_out = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign capture   = I_AHBS_HSEL && I_AHBS_HREADY && I_AHBS_HTRANS[1] && ready_out;
    assign haddr_idx = I_AHBS_HADDR[AW+1:2];
    assign in_range  = (I_AHBS_HADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign cap_legal = in_range && aligned;

    always_comb begin
        aligned = 1'b0;
        case (I_AHBS_HSIZE)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~I_AHBS_HADDR[0];
            3'd2:    aligned = (I_AHBS_HADDR[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: if (wait_cnt == 2'd1) state_nxt = S_DATA;
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!capture)               state_nxt = S_IDLE;
                else if (!cap_legal)        state_nxt = S_ERR1;
                else if (WAIT_STATES == 0)  state_nxt = S_DATA;
                else                        state_nxt = S_WAIT;
            end
        endcase
    end

    always_comb begin
        cap_be = 4'b0000;
        case (cap_size)
            2'd0:    cap_be[cap_lane] = 1'b1;
            2'd1:    cap_be = cap_lane[1] ? 4'b1100 : 4'b0011;
            default: cap_be = 4'b1111;
        endcase
    end

    assign commit   = (state == S_DATA) && valid && cap_write && !I_AHBS_RESET;
    assign old_word = mem[cap_idx];
    assign bus_word = mem[haddr_idx];
    assign fwd      = commit && (haddr_idx == cap_idx);

    // Merged word as it will look after this cycle's commit; feeds same-cycle read forwarding.
    always_comb begin
        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) wr_word[8*i +: 8] = I_AHBS_HWDATA[8*i +: 8];
        end
    end

    always_ff @(posedge I_AHBS_HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && cap_be[i]) mem[cap_idx][8*i +: 8] <= I_AHBS_HWDATA[8*i +: 8];
        end
    end

    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_RESET) begin
            state     <= S_IDLE;
            valid     <= 1'b0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_size  <= 2'd0;
            cap_lane  <= 2'd0;
            wait_cnt  <= 2'd0;
            rdata     <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT) wait_cnt <= wait_cnt - 2'd1;
            if (ready_out) begin
                valid <= capture;
                if (capture) begin
                    cap_idx   <= haddr_idx;
                    cap_write <= I_AHBS_HWRITE;
                    cap_size  <= I_AHBS_HSIZE[1:0];
                    cap_lane  <= I_AHBS_HADDR[1:0];
                    wait_cnt  <= WS;
                end
            end
            // Zero-wait reads load straight from the address phase; waited reads load as WAIT ends.
            if (WAIT_STATES == 0 && capture && cap_legal && !I_AHBS_HWRITE)
                rdata <= fwd ? wr_word : bus_word;
            else if (state == S_WAIT && wait_cnt == 2'd1 && !cap_write)
                rdata <= old_word;
        end
    end

    assign O_AHBS_HREADYOUT = ready_out;
    assign O_AHBS_HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
    assign O_AHBS_HRDATA    = rdata;

endmodule

// File: tb/tb_ahbslv_mem.sv
// tb/tb_ahbslv_mem.sv - scoreboard bench for ahbslv_mem at zero and two wait states
`timescale 1ns/1ps
module tb_ahbslv_mem;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct {
        bit          act;
        bit          rd;
        bit          err;
        int          waits;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  hsel = 2'b00;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = 32'h0;
    wire  [1:0]        ro;
    wire  [1:0][1:0]   resp;
    wire  [1:0][31:0]  rdata;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq [2][$];
    logic [31:0] model [2][64];
    logic [31:0] pend_wdata [2];
    bit          dp [2];
    int          nw [2];
    logic [1:0]  wresp [2];
    logic [31:0] last_rd [2];
    exp_t        me;

    always #5 clk = ~clk;

    ahbslv_mem #(.AW(6), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .I_AHBS_HCLK(clk), .I_AHBS_RESET(rst), .I_AHBS_HSEL(hsel[0]), .I_AHBS_HADDR(haddr),
        .I_AHBS_HTRANS(htrans), .I_AHBS_HWRITE(hwrite), .I_AHBS_HSIZE(hsize), .I_AHBS_HBURST(hburst),
        .I_AHBS_HWDATA(hwdata), .I_AHBS_HREADY(ro[0]), .O_AHBS_HREADYOUT(ro[0]),
        .O_AHBS_HRESP(resp[0]), .O_AHBS_HRDATA(rdata[0]));

    ahbslv_mem #(.AW(6), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut2 (
        .I_AHBS_HCLK(clk), .I_AHBS_RESET(rst), .I_AHBS_HSEL(hsel[1]), .I_AHBS_HADDR(haddr),
        .I_AHBS_HTRANS(htrans), .I_AHBS_HWRITE(hwrite), .I_AHBS_HSIZE(hsize), .I_AHBS_HBURST(hburst),
        .I_AHBS_HWDATA(hwdata), .I_AHBS_HREADY(ro[1]), .O_AHBS_HREADYOUT(ro[1]),
        .O_AHBS_HRESP(resp[1]), .O_AHBS_HRDATA(rdata[1]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Reference: each beat is resolved against a flat word array in issue order.
    task automatic beat(input int d, input bit sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] off, input logic [31:0] wd,
                        input bit use_want = 1'b0, input logic [31:0] want = 32'h0);
        exp_t e;
        int   n;
        int   lane;
        e.act   = tr[1];
        e.rd    = !wr;
        e.err   = tr[1] && (off >= 32'd256 || sz > 3'd2 || (sz == 3'd1 && off[0]) ||
                            (sz == 3'd2 && off[1:0] != 2'b00));
        e.waits = e.err ? 1 : (tr[1] ? ws_of(d) : 0);
        e.data  = 32'h0;
        if (sel && tr[1] && !e.err) begin
            if (wr) begin
                for (int b = 0; b < (1 << sz); b++) begin
                    lane = int'(off[1:0]) + b;
                    model[d][off[7:2]][8*lane +: 8] = wd[8*lane +: 8];
                end
            end else begin
                e.data = use_want ? want : model[d][off[7:2]];
            end
        end
        hsel   = sel ? 2'(1 << d) : 2'b00;
        htrans = sel ? tr : T_IDLE;
        haddr  = BASE + off;
        hwrite = wr;
        hsize  = sz;
        hwdata = pend_wdata[d];
        n = 0;
        @(negedge clk);
        while (!ro[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("d%0d ready_bound", d), 32'(ro[d]), 32'd1);
        @(posedge clk);
        #1;
        pend_wdata[d] = wd;
        if (sel) sbq[d].push_back(e);
    endtask

    task automatic flush(input int d);
        beat(d, 1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                dp[d] = 1'b0;
                sbq[d].delete();
                last_rd[d] = 32'h0;
            end else begin
                if (dp[d]) begin
                    if (!ro[d]) begin
                        nw[d]++;
                        wresp[d] = resp[d];
                        if (nw[d] > 8) begin
                            chk($sformatf("d%0d stall_bound", d), 32'(nw[d]), 32'd8);
                            dp[d] = 1'b0;
                        end
                    end else begin
                        if (sbq[d].size() == 0) begin
                            chk($sformatf("d%0d sb_underflow", d), 32'd0, 32'd1);
                        end else begin
                            me = sbq[d].pop_front();
                            chk($sformatf("d%0d waits", d), 32'(nw[d]), 32'(me.waits));
                            chk($sformatf("d%0d hresp", d), 32'(resp[d]), me.err ? 32'd1 : 32'd0);
                            if (nw[d] > 0)
                                chk($sformatf("d%0d wait_hresp", d), 32'(wresp[d]), me.err ? 32'd1 : 32'd0);
                            if (me.act && me.rd && !me.err) begin
                                chk($sformatf("d%0d hrdata", d), rdata[d], me.data);
                                last_rd[d] = me.data;
                            end else begin
                                chk($sformatf("d%0d hrdata_hold", d), rdata[d], last_rd[d]);
                            end
                        end
                        dp[d] = 1'b0;
                    end
                end else begin
                    chk($sformatf("d%0d idle_ready", d), 32'(ro[d]), 32'd1);
                end
                if (hsel[d] && ro[d]) begin
                    dp[d] = 1'b1;
                    nw[d] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] off;
        logic [2:0]  sz;
        logic [1:0]  tr;
        bit          sel;
        int          r;
        pend_wdata[0] = 32'h0;
        pend_wdata[1] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_hreadyout", d), 32'(ro[d]), 32'd1);
            chk($sformatf("d%0d rst_hresp", d), 32'(resp[d]), 32'd0);
            chk($sformatf("d%0d rst_hrdata", d), rdata[d], 32'h0);
        end
        @(posedge clk);
        #1;

        // SRAM is not initialised, so give the model known contents first.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++)
                beat(d, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom);
            flush(d);
        end

        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'h11223344);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd0, 32'h21, 32'h0000AA00);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd1, 32'h22, 32'hBBCC0000);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 32'hBBCCAA44);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h40, 32'd1);
        beat(0, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h44, 32'd2);
        beat(0, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h48, 32'd3);
        beat(0, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h4C, 32'd4);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h4C, 32'h0, 1'b1, 32'd4);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h41, 32'hCAFE0001);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h100, 32'hCAFE0002);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd3, 32'h44, 32'hCAFE0003);
        beat(0, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'hFFFF_FFFC, 32'hCAFE0004);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'd1);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h44, 32'h0, 1'b1, 32'd2);
        beat(0, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'hFC, 32'h0);
        flush(0);

        beat(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        beat(1, 1'b1, T_NSEQ, 1'b1, 3'd2, 32'h60, 32'hA5A5_0001);
        beat(1, 1'b1, T_BUSY, 1'b1, 3'd2, 32'h64, 32'h0);
        beat(1, 1'b1, T_SEQ,  1'b1, 3'd2, 32'h64, 32'h5A5A_0002);
        beat(1, 1'b1, T_BUSY, 1'b0, 3'd2, 32'h60, 32'h0);
        beat(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h60, 32'h0, 1'b1, 32'hA5A5_0001);
        beat(1, 1'b1, T_SEQ,  1'b0, 3'd2, 32'h64, 32'h0, 1'b1, 32'h5A5A_0002);
        beat(1, 1'b1, T_NSEQ, 1'b1, 3'd0, 32'h103, 32'h0);
        flush(1);

        hsel = 2'b10; htrans = T_NSEQ; haddr = BASE + 32'h80; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        @(posedge clk);
        #1;
        hsel = 2'b00; htrans = T_IDLE; hwdata = 32'h55AA55AA; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid hreadyout", 32'(ro[1]), 32'd1);
        chk("rst_mid hresp", 32'(resp[1]), 32'd0);
        chk("rst_mid hrdata", rdata[1], 32'h0);
        @(posedge clk);
        #1;
        beat(1, 1'b1, T_NSEQ, 1'b0, 3'd2, 32'h80, 32'h0);
        flush(1);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 300; k++) begin
                r = $urandom_range(0, 15);
                if (r == 0)      off = 32'h100 + 32'($urandom_range(0, 255));
                else if (r == 1) off = 32'hFFFF_FFFC;
                else             off = 32'($urandom_range(0, 255));
                r  = $urandom_range(0, 9);
                sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
                if ($urandom_range(0, 4) != 0) begin
                    if (sz == 3'd1) off[0] = 1'b0;
                    if (sz == 3'd2) off[1:0] = 2'b00;
                end
                r   = $urandom_range(0, 11);
                sel = (r != 11);
                tr  = (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
                beat(d, sel, tr, 1'($urandom_range(0, 1)), sz, off, $urandom);
            end
            flush(d);
        end

        repeat (3) @(negedge clk);
        chk("d0 sb_drained", 32'(sbq[0].size()), 32'd0);
        chk("d1 sb_drained", 32'(sbq[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
